recip_arbiter: RTL

Time-shares the single iterative `recip16` reciprocal unit between up to four requesters in the VGA demo pipeline. Requesters include:

- the per-line plane `dx` computation;
- scroller and zoom scale factors;
- sprite perspective terms.

Each requester raises a level request with its denominator. The block grants requesters round-robin, sequences the divider's start pulse and latency window, captures the result, and returns it with a one-cycle done pulse. It sits between the effect generators and the `recip16` instance, and owns that instance's `start` and `denom` inputs.

---
 rtl/recip_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/recip_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : recip_arbiter
// Description : Round-robin time-sharing of one iterative recip16 reciprocal
//               unit between four requesters. Issues the divider start pulse,
//               waits out the fixed latency, captures the result and returns
//               it with a one-cycle done pulse. Zero denominators bypass the
//               divider and return all ones.
// Ports       : clk48, rst_n (sync, active-low)
//               req[3:0], denom_flat[4*DW-1:0]     requester side
//               grant[3:0], done[3:0], result, busy requester side outputs
//               div_start, div_denom, div_recip     recip16 side
// Revision    : 1.0 - initial release
// ============================================================================
module recip_arbiter #(
  parameter int DW          = 10,
  parameter int RW          = 11,
  parameter int DIV_LATENCY = 16
) (
  input  logic            clk48,
  input  logic            rst_n,
  input  logic [3:0]      req,
  input  logic [4*DW-1:0] denom_flat,
  output logic [3:0]      grant,
  output logic [3:0]      done,
  output logic [RW-1:0]   result,
  output logic            busy,
  output logic            div_start,
  output logic [DW-1:0]   div_denom,
  input  logic [RW-1:0]   div_recip
);

  localparam int CW = $clog2(DIV_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_ZERO  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    grant_q, grant_d;
  logic [3:0]    done_q, done_d;
  logic [RW-1:0] result_q, result_d;
  logic          busy_q, busy_d;
  logic          div_start_q, div_start_d;
  logic [DW-1:0] div_denom_q, div_denom_d;

  // Round-robin scan: first requesting index at or after ptr, wrapping.
  logic          scan_found;
  logic [1:0]    scan_sel;
  logic [1:0]    scan_idx;
  logic [DW-1:0] scan_denom;

  always_comb begin
    scan_found = 1'b0;
    scan_sel   = ptr_q;
    scan_idx   = ptr_q;
    for (int k = 0; k < 4; k++) begin
      scan_idx = ptr_q + k[1:0];
      if (!scan_found && req[scan_idx]) begin
        scan_found = 1'b1;
        scan_sel   = scan_idx;
      end
    end
    scan_denom = denom_flat[scan_sel*DW +: DW];
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    done_d      = 4'b0000;
    result_d    = result_q;
    div_start_d = 1'b0;
    div_denom_d = div_denom_q;

    case (state_q)
      S_IDLE: begin
        grant_d = 4'b0000;
        if (scan_found) begin
          sel_d       = scan_sel;
          grant_d     = 4'b0001 << scan_sel;
          div_denom_d = scan_denom;
          ptr_d       = scan_sel + 2'd1;
          if (scan_denom == '0) begin
            state_d = S_ZERO;
          end else begin
            // Registered start pulse lands in the START cycle.
            state_d     = S_START;
            div_start_d = 1'b1;
          end
        end
      end
      S_START: begin
        cnt_d   = CW'(DIV_LATENCY - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          result_d = div_recip;
          done_d   = 4'b0001 << sel_q;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_ZERO: begin
        result_d = '1;
        done_d   = 4'b0001 << sel_q;
        state_d  = S_DONE;
      end
      S_DONE: begin
        grant_d = 4'b0000;
        state_d = S_IDLE;
      end
      default: begin
        grant_d = 4'b0000;
        state_d = S_IDLE;
      end
    endcase

    // busy is registered, so it follows the state being entered.
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk48) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= 2'd0;
      sel_q       <= 2'd0;
      cnt_q       <= '0;
      grant_q     <= 4'b0000;
      done_q      <= 4'b0000;
      result_q    <= '0;
      busy_q      <= 1'b0;
      div_start_q <= 1'b0;
      div_denom_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      result_q    <= result_d;
      busy_q      <= busy_d;
      div_start_q <= div_start_d;
      div_denom_q <= div_denom_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign result    = result_q;
  assign busy      = busy_q;
  assign div_start = div_start_q;
  assign div_denom = div_denom_q;

endmodule
`default_nettype wire
